// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple segment per stage,
// operand skew ahead of the carry, sum de-skew behind it, valid/ready flow control.
module pipelined_rca #(
   parameter int WIDTH = 14,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTAGE = (WIDTH + SEG - 1) / SEG;

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   function automatic int seg_lo(input int k);
      return k * SEG;
   endfunction

   function automatic int seg_w(input int k);
      return (k == NSTAGE - 1) ? (WIDTH - k * SEG) : SEG;
   endfunction

   function automatic logic [WIDTH:0] seg_mask(input int k);
      return {(WIDTH + 1){1'b1}} >> (WIDTH + 1 - seg_w(k));
   endfunction

   // Word layout: bits below segment k already hold sum, bits from segment k up
   // still hold A. Returns {carry out of segment k, word with segment k summed}.
   function automatic logic [WIDTH:0] seg_sum(input logic [WIDTH-1:0] aw,
                                              input logic [WIDTH-1:0] bw,
                                              input logic             c,
                                              input int               k);
      logic [WIDTH:0] mask, a_s, b_s, t, r;
      logic           cy;
      mask = seg_mask(k);
      a_s  = ({1'b0, aw} >> seg_lo(k)) & mask;
      b_s  = ({1'b0, bw} >> seg_lo(k)) & mask;
      t    = a_s + b_s + {{WIDTH{1'b0}}, c};
      cy   = |((t >> seg_w(k)) & ONE);
      r    = ({1'b0, aw} & ~(mask << seg_lo(k))) | ((t & mask) << seg_lo(k));
      r[WIDTH] = cy;
      return r;
   endfunction

   // Overflow of the top segment: carry into the MSB xor carry out of the MSB.
   function automatic logic seg_ovf(input logic [WIDTH-1:0] aw,
                                    input logic [WIDTH-1:0] bw,
                                    input logic             c);
      logic [WIDTH:0] mask, a_s, b_s, t;
      logic           cy, cmsb;
      mask = seg_mask(NSTAGE - 1);
      a_s  = ({1'b0, aw} >> seg_lo(NSTAGE - 1)) & mask;
      b_s  = ({1'b0, bw} >> seg_lo(NSTAGE - 1)) & mask;
      t    = a_s + b_s + {{WIDTH{1'b0}}, c};
      cy   = |((t >> seg_w(NSTAGE - 1)) & ONE);
      cmsb = |(((t ^ a_s ^ b_s) >> (seg_w(NSTAGE - 1) - 1)) & ONE);
      return cmsb ^ cy;
   endfunction

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [WIDTH-1:0] top_a, top_b;
   logic             top_c, top_v;
   logic [WIDTH:0]   top_r;
   logic             out_vld_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   assign en       = !out_vld_q || out_ready;
   assign in_ready = en;

   // Subtraction as a + ~b + 1; the external carry-in only matters when adding.
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub | cin;

   if (NSTAGE > 1) begin : g_skew
      logic [WIDTH:0]   r_d [NSTAGE-1];
      logic [WIDTH:0]   r_q [NSTAGE-1];
      logic [WIDTH-1:0] b_q [NSTAGE-1];
      logic             vld_q [NSTAGE-1];

      always_comb begin
         r_d[0] = seg_sum(a, b_eff, c_eff, 0);
         for (int k = 1; k < NSTAGE - 1; k++) begin
            r_d[k] = seg_sum(r_q[k-1][WIDTH-1:0], b_q[k-1], r_q[k-1][WIDTH], k);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < NSTAGE - 1; k++) begin
               vld_q[k] <= 1'b0;
            end
         end else if (en) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < NSTAGE - 1; k++) begin
               vld_q[k] <= vld_q[k-1];
            end
         end
      end

      // Partial sums and remaining operand bits carry no reset; vld_q qualifies them.
      always_ff @(posedge clk) begin
         if (en) begin
            r_q    <= r_d;
            b_q[0] <= b_eff;
            for (int k = 1; k < NSTAGE - 1; k++) begin
               b_q[k] <= b_q[k-1];
            end
         end
      end

      assign top_a = r_q[NSTAGE-2][WIDTH-1:0];
      assign top_b = b_q[NSTAGE-2];
      assign top_c = r_q[NSTAGE-2][WIDTH];
      assign top_v = vld_q[NSTAGE-2];
   end else begin : g_single
      assign top_a = a;
      assign top_b = b_eff;
      assign top_c = c_eff;
      assign top_v = in_valid;
   end

   assign top_r = seg_sum(top_a, top_b, top_c, NSTAGE - 1);

   // Final stage: result registers load only on a valid beat so they read 0
   // after reset and keep the last result through bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (en) begin
         out_vld_q <= top_v;
         if (top_v) begin
            sum_q  <= top_r[WIDTH-1:0];
            cout_q <= top_r[WIDTH];
            ovf_q  <= seg_ovf(top_a, top_b, top_c);
         end
      end
   end

   assign out_valid = out_vld_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed scenarios at WIDTH=14/SEG=4 plus a
// randomized flow-control sweep over several segment sizes.
module tb_pipelined_rca;

   localparam int NBEAT = 10000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic srst = 1'b1;

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Directed DUT
   logic        m_iv, m_ir, m_ov, m_ordy, m_ci, m_sb, m_co, m_of;
   logic [13:0] m_a, m_b, m_s;

   pipelined_rca #(.WIDTH(14), .SEG(4)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(m_iv), .in_ready(m_ir),
      .a(m_a), .b(m_b), .cin(m_ci), .sub(m_sb),
      .out_valid(m_ov), .out_ready(m_ordy),
      .sum(m_s), .cout(m_co), .ovf(m_of)
   );

   task automatic one_beat(input string tag, input logic [13:0] a, input logic [13:0] b,
                           input logic ci, input logic sb,
                           input logic [13:0] es, input logic ec, input logic eo);
      @(negedge clk);
      m_iv = 1'b1; m_a = a; m_b = b; m_ci = ci; m_sb = sb; m_ordy = 1'b1;
      #1 chk({tag, "_rdy"}, 64'(m_ir), 64'(1));
      @(negedge clk);
      m_iv = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk({tag, "_early"}, 64'(m_ov), 64'(0));
      @(negedge clk);
      #1 chk({tag, "_vld"}, 64'(m_ov), 64'(1));
      chk(tag, 64'({m_of, m_co, m_s}), 64'({eo, ec, es}));
   endtask

   task automatic backpressure();
      int nb, k;
      nb = 0;
      k  = 0;
      for (int c = 0; c < 60 && k < 8; c++) begin
         @(negedge clk);
         m_ordy = !(c >= 5 && c <= 9);
         m_iv   = (nb < 8);
         m_a    = 14'(nb);
         m_b    = 14'(nb);
         m_ci   = 1'b1;
         m_sb   = 1'b0;
         #1;
         if (c >= 5 && c <= 9) begin
            chk("bp_stall_rdy", 64'(m_ir), 64'(0));
            chk("bp_hold", 64'({m_ov, m_co, m_s}), 64'({1'b1, 1'b0, 14'(2 * k + 1)}));
         end
         if (m_iv && m_ir) nb++;
         if (m_ov && m_ordy) begin
            chk("bp_data", 64'({m_co, m_s}), 64'({1'b0, 14'(2 * k + 1)}));
            k++;
         end
      end
      chk("bp_count", 64'(k), 64'(8));
      chk("bp_accepted", 64'(nb), 64'(8));
      @(negedge clk);
      m_iv = 1'b0;
      #1 chk("bp_nodup", 64'(m_ov), 64'(0));
   endtask

   task automatic reset_midstream();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         m_iv = 1'b1; m_a = 14'(16 * (c + 1)); m_b = 14'h0001; m_ci = 1'b0; m_sb = 1'b0;
         m_ordy = 1'b1;
      end
      @(negedge clk);
      m_iv = 1'b0; m_ordy = 1'b0;
      #1 chk("rst_pre_vld", 64'(m_ov), 64'(1));
      chk("rst_pre_sum", 64'(m_s), 64'(14'h0011));
      #1 rst = 1'b1;
      #1;
      chk("rst_async_vld", 64'(m_ov), 64'(0));
      chk("rst_async_rdy", 64'(m_ir), 64'(1));
      chk("rst_async_out", 64'({m_of, m_co, m_s}), 64'(0));
      #1 rst = 1'b0;
      m_ordy = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1 chk("rst_nostale", 64'(m_ov), 64'(0));
      end
      one_beat("post_rst", 14'h0100, 14'h0200, 1'b0, 1'b0, 14'h0300, 1'b0, 1'b0);
   endtask

   // Randomized sweep over segment sizes against an arithmetic model.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int S  = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 14;
      localparam int NS = (14 + S - 1) / S;

      logic        iv = 1'b0, ordy = 1'b0, ci = 1'b0, sb = 1'b0;
      logic        ir, ov, co, of;
      logic [13:0] aa = '0, bb = '0, ss;
      logic        done = 1'b0;

      pipelined_rca #(.WIDTH(14), .SEG(S)) u_sw (
         .clk(clk), .rst(srst),
         .in_valid(iv), .in_ready(ir),
         .a(aa), .b(bb), .cin(ci), .sub(sb),
         .out_valid(ov), .out_ready(ordy),
         .sum(ss), .cout(co), .ovf(of)
      );

      initial begin
         logic [15:0] dq[$];
         int          stq[$];
         int          acc, cyc, ecnt, st;
         logic [15:0] d;
         logic [14:0] full;
         logic [13:0] be;
         logic        ce, eo;
         string       tag;
         tag  = $sformatf("sweep_seg%0d", S);
         acc  = 0;
         cyc  = 0;
         ecnt = 0;
         wait (srst == 1'b0);
         while ((acc < NBEAT || dq.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            iv   = (acc < NBEAT) && ($urandom_range(3) != 0);
            aa   = 14'($urandom);
            bb   = 14'($urandom);
            ci   = 1'($urandom);
            sb   = ($urandom_range(3) == 0);
            ordy = ($urandom_range(3) != 0);
            #1;
            if (ov && ordy) begin
               if (dq.size() == 0) begin
                  chk({tag, "_spurious"}, 64'(1), 64'(0));
               end else begin
                  d  = dq.pop_front();
                  st = stq.pop_front();
                  chk(tag, 64'({32'(ecnt - st), of, co, ss}), 64'({32'(NS), d}));
               end
            end
            if (iv && ir) begin
               be   = sb ? ~bb : bb;
               ce   = sb | ci;
               full = {1'b0, aa} + {1'b0, be} + {14'd0, ce};
               eo   = (aa[13] == be[13]) && (full[13] != aa[13]);
               dq.push_back({eo, full});
               stq.push_back(ecnt);
               acc++;
            end
            if (ir) ecnt++;
            cyc++;
         end
         chk({tag, "_done"}, 64'({acc == NBEAT, dq.size() == 0}), 64'(2'b11));
         iv   = 1'b0;
         done = 1'b1;
      end
   end

   initial begin
      logic all_done;
      m_iv = 1'b0; m_a = '0; m_b = '0; m_ci = 1'b0; m_sb = 1'b0; m_ordy = 1'b1;
      rst = 1'b1;
      #1;
      chk("reset_vld", 64'(m_ov), 64'(0));
      chk("reset_rdy", 64'(m_ir), 64'(1));
      chk("reset_out", 64'({m_of, m_co, m_s}), 64'(0));
      #20 rst = 1'b0;
      srst = 1'b0;

      one_beat("full_carry", 14'h3FFF, 14'h0001, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b0);
      one_beat("sub_borrow", 14'h0005, 14'h0007, 1'b0, 1'b1, 14'h3FFE, 1'b0, 1'b0);
      one_beat("signed_ovf", 14'h1FFF, 14'h0001, 1'b0, 1'b0, 14'h2000, 1'b0, 1'b1);
      one_beat("add_cin",    14'h0ABC, 14'h0123, 1'b1, 1'b0, 14'h0BE0, 1'b0, 1'b0);
      one_beat("sub_equal",  14'h1234, 14'h1234, 1'b1, 1'b1, 14'h0000, 1'b1, 1'b0);
      one_beat("neg_ovf",    14'h2000, 14'h3FFF, 1'b0, 1'b0, 14'h1FFF, 1'b1, 1'b1);
      one_beat("sub_ovf",    14'h2000, 14'h0001, 1'b0, 1'b1, 14'h1FFF, 1'b1, 1'b1);

      backpressure();
      reset_midstream();

      all_done = 1'b0;
      for (int w = 0; w < 50000 && !all_done; w++) begin
         @(negedge clk);
         all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done;
      end
      chk("sweep_all_done", 64'(all_done), 64'(1));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 The block SHALL have the parameters listed below, one per line: name, default, meaning.
- WIDTH, 14, operand/sum width in bits; legal range ≥ 2.
- SEG, 4, bits per pipeline segment; legal range 1..WIDTH.
- NSTAGE = ceil(WIDTH/SEG), derived and not overridable; the top segment holds WIDTH-(NSTAGE-1)*SEG bits.

REQ-002 The block SHALL have the ports listed below, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, operand beat offered.
- in_ready, out, 1, block can accept a beat this cycle.
- a, in, WIDTH, operand A.
- b, in, WIDTH, operand B.
- cin, in, 1, carry-in (add mode only).
- sub, in, 1, 1 = compute a-b; 0 = compute a+b+cin.
- out_valid, out, 1, result beat present.
- out_ready, in, 1, downstream accepts result.
- sum, out, WIDTH, result.
- cout, out, 1, carry out of the MSB; in subtract mode this is the not-borrow flag.
- ovf, out, 1, two's-complement overflow.

REQ-003 The block SHALL have exactly one clock (clk), and its reset (rst) SHALL be asynchronous and active-high.

Function
REQ-004 An input beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-005 Internal stall enable en SHALL equal !out_valid || out_ready.
- in_ready SHALL equal en (combinational).
- All pipeline registers SHALL advance only when en=1 and SHALL hold otherwise.
REQ-006 On acceptance with sub=1:
- the effective B SHALL be ~b;
- the effective carry-in SHALL be 1;
- the cin input SHALL be ignored.
REQ-007 With sub=0, the effective B SHALL be b and the effective carry-in SHALL be cin.
REQ-008 Stage k (k=0..NSTAGE-1) SHALL ripple-add segment k of A and effective B with the carry registered from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-009 Operand segments above stage k SHALL be carried forward in skew registers.
REQ-010 Completed lower sum segments SHALL be delayed in de-skew registers so that all WIDTH sum bits of one beat emerge together.
REQ-011 Latency SHALL be exactly NSTAGE enabled cycles from acceptance to out_valid=1 with that beat's result.
REQ-012 With out_ready held at 1, throughput SHALL be one beat per cycle and no bubbles SHALL be inserted.
REQ-013 A valid bit SHALL travel with each stage. out_valid SHALL be the final stage's valid bit, and a bubble (in_valid=0 while en=1) SHALL propagate as valid=0.
REQ-014 The result SHALL satisfy {cout,sum} = A + effective B + effective carry-in, computed at WIDTH+1 bits with no truncation other than cout.
REQ-015 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, both taken from the top stage.
REQ-016 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable and no beat SHALL be lost or duplicated.
REQ-017 A new beat presented in the same cycle as out_valid && out_ready SHALL be accepted, because en=1.
REQ-018 Pipeline registers SHALL advance regardless of in_valid whenever en=1.
REQ-019 When WIDTH is an exact multiple of SEG, all segments SHALL be SEG bits wide.
REQ-020 When SEG=WIDTH, NSTAGE=1 and latency SHALL be 1.

Reset
REQ-021 Asserting rst SHALL, without waiting for clk, clear all valid bits, so out_valid=0 and in_ready=1.
REQ-022 Asserting rst SHALL clear sum, cout and ovf to 0.
REQ-023 Reset mid-operation SHALL discard all in-flight beats.
REQ-024 After rst deasserts, the first accepted beat SHALL appear after NSTAGE cycles.
REQ-025 Data skew registers need not be reset; outputs SHALL nevertheless read 0 until the first valid result.

Verification
REQ-026 The bench SHALL cover the directed scenarios below, each at WIDTH=14, SEG=4 (NSTAGE=4), in the form stimulus -> required response.
- Full carry ripple: a=0x3FFF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0x3FFE, cout=0, ovf=0.
- Signed overflow: a=0x1FFF, b=0x0001, cin=0, sub=0 -> sum=0x2000, cout=0, ovf=1.
- Backpressure: 8 back-to-back beats (a=i, b=i, cin=1), with out_ready=0 for cycles 5-9 -> results 2i+1 in order, none lost or duplicated, outputs held stable while stalled, in_ready=0 while stalled.
- Reset mid-stream: rst pulsed asynchronously with 3 beats in flight -> out_valid=0 immediately, no stale beat emitted; a beat accepted after release appears exactly 4 cycles later.
- Parameter sweep: SEG in {1,3,4,14} against a random model, 10k beats with random valid/ready -> zero mismatches, latency = NSTAGE.
